// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial MSB-first pattern transmitter with repeat count and optional inter-repeat gap.
// Optional even-parity bit after each pattern is compiled in with SEQ_PATTERN_GEN_PARITY_EN.
module seq_pattern_gen #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             ready,
  output logic             d_out,
  output logic             d_valid,
  output logic             done,
  output logic [2:0]       present
);

  localparam logic [2:0] IDLE  = 3'b000;
  localparam logic [2:0] SHIFT = 3'b001;
  localparam logic [2:0] GAP   = 3'b010;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
  localparam logic [2:0] PAR   = 3'b011;
`endif
  localparam logic [2:0] DONE  = 3'b100;

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [2:0]       state,   nxt_state;
  logic [WIDTH-1:0] pat,     nxt_pat;
  logic [WIDTH-1:0] shreg,   nxt_sh;
  logic [BW-1:0]    bit_cnt, nxt_bit;
  logic [CNT_W-1:0] rep_cnt, nxt_rep;
  logic [GW-1:0]    gap_cnt, nxt_gap;
  logic             nxt_dout, nxt_dvalid, nxt_done;
  logic             busy, seg_end, reload;
  logic [CNT_W-1:0] rem;

  assign present = state;

  always_comb begin
    nxt_state  = state;
    nxt_pat    = pat;
    nxt_sh     = shreg;
    nxt_bit    = bit_cnt;
    nxt_rep    = rep_cnt;
    nxt_gap    = gap_cnt;
    nxt_dout   = 1'b0;
    nxt_dvalid = 1'b0;
    nxt_done   = 1'b0;
    busy       = 1'b1;
    seg_end    = 1'b0;
    reload     = 1'b0;
    rem        = '0;

    case (state)
      SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          nxt_rep = rep_cnt - 1'b1;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
          nxt_state  = PAR;
          nxt_dout   = ^pat;
          nxt_dvalid = 1'b1;
`else
          seg_end = 1'b1;
          rem     = rep_cnt - 1'b1;
`endif
        end else begin
          nxt_sh     = {shreg[WIDTH-2:0], 1'b0};
          nxt_bit    = bit_cnt + 1'b1;
          nxt_dout   = shreg[WIDTH-2];
          nxt_dvalid = 1'b1;
        end
      end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      PAR: begin
        // repeat counter was already decremented on the last pattern bit
        seg_end = 1'b1;
        rem     = rep_cnt;
      end
`endif
      GAP: begin
        if (gap_cnt == GAP_LAST) reload = 1'b1;
        else                     nxt_gap = gap_cnt + 1'b1;
      end
      DONE: nxt_state = IDLE;
      default: begin
        busy      = 1'b0;
        nxt_state = IDLE;
        if (start && !abort) begin
          nxt_pat = pattern_in;
          nxt_rep = repeat_n;
          if (repeat_n == '0) begin
            nxt_state = DONE;
            nxt_done  = 1'b1;
          end else begin
            nxt_state  = SHIFT;
            nxt_sh     = pattern_in;
            nxt_bit    = '0;
            nxt_dout   = pattern_in[WIDTH-1];
            nxt_dvalid = 1'b1;
          end
        end
      end
    endcase

    if (seg_end) begin
      if (rem == '0) begin
        nxt_state = DONE;
        nxt_done  = 1'b1;
      end else if (GAP_CYCLES > 0) begin
        nxt_state = GAP;
        nxt_gap   = '0;
      end else begin
        reload = 1'b1;
      end
    end

    if (reload) begin
      nxt_state  = SHIFT;
      nxt_sh     = pat;
      nxt_bit    = '0;
      nxt_dout   = pat[WIDTH-1];
      nxt_dvalid = 1'b1;
    end

    // abort overrides whatever the busy states decided above
    if (abort && busy) begin
      nxt_state  = IDLE;
      nxt_dout   = 1'b0;
      nxt_dvalid = 1'b0;
      nxt_done   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pat     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      ready   <= 1'b1;
      d_out   <= 1'b0;
      d_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt_state;
      pat     <= nxt_pat;
      shreg   <= nxt_sh;
      bit_cnt <= nxt_bit;
      rep_cnt <= nxt_rep;
      gap_cnt <= nxt_gap;
      ready   <= (nxt_state == IDLE);
      d_out   <= nxt_dout;
      d_valid <= nxt_dvalid;
      done    <= nxt_done;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - scoreboard bench for seq_pattern_gen, back-to-back and gapped instances.
module tb_seq_pattern_gen;
  localparam int W  = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic       ready;
    logic       dv;
    logic       dout;
    logic       done;
    logic [2:0] present;
  } exp_t;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic          reset, start, abort;
  logic [W-1:0]  pattern_in;
  logic [CW-1:0] repeat_n;
  logic ready0, d_out0, d_valid0, done0;
  logic ready1, d_out1, d_valid1, done1;
  logic [2:0] present0, present1;

  seq_pattern_gen #(.WIDTH(W), .CNT_W(CW), .GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern_in(pattern_in), .repeat_n(repeat_n),
    .ready(ready0), .d_out(d_out0), .d_valid(d_valid0), .done(done0), .present(present0));

  seq_pattern_gen #(.WIDTH(W), .CNT_W(CW), .GAP_CYCLES(2)) u_gap2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern_in(pattern_in), .repeat_n(repeat_n),
    .ready(ready1), .d_out(d_out1), .d_valid(d_valid1), .done(done1), .present(present1));

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  bit   hold = 1'b0;

  function automatic exp_t mk(logic r, logic v, logic d, logic dn, logic [2:0] p);
    return {r, v, d, dn, p};
  endfunction

  task automatic cmp(input string nm, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got ready=%b valid=%b dout=%b done=%b present=%0d, expected ready=%b valid=%b dout=%b done=%b present=%0d",
               nm, $time, got.ready, got.dv, got.dout, got.done, got.present,
               exp.ready, exp.dv, exp.dout, exp.done, exp.present);
    end
  endtask

  // Expected cycle-by-cycle trace following the start edge, truncated at an abort.
  task automatic model(input int inst, input logic [W-1:0] p, input int rep, input int gap, input int ab);
    exp_t t[$];
    for (int r = 0; r < rep; r++) begin
      for (int b = W - 1; b >= 0; b--) t.push_back(mk(1'b0, 1'b1, p[b], 1'b0, 3'd1));
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      t.push_back(mk(1'b0, 1'b1, ^p, 1'b0, 3'd3));
`endif
      if (r < rep - 1)
        for (int g = 0; g < gap; g++) t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd2));
    end
    t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd4));
    t.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    if (ab >= 0 && ab < t.size() - 1) begin
      while (t.size() > ab + 1) void'(t.pop_back());
      t.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    end
    foreach (t[i]) begin
      if (inst == 0) q0.push_back(t[i]);
      else           q1.push_back(t[i]);
    end
  endtask

  always @(negedge clk) begin
    if (!hold && q0.size() > 0) cmp("gap0", {ready0, d_valid0, d_out0, done0, present0}, q0.pop_front());
    if (!hold && q1.size() > 0) cmp("gap2", {ready1, d_valid1, d_out1, done1, present1}, q1.pop_front());
  end

  task automatic drain();
    int budget = 0;
    while ((q0.size() > 0 || q1.size() > 0) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: pending gap0=%0d gap2=%0d, expected 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic run(input logic [W-1:0] p, input int rep, input int ab, input bit busy, input int rst_at);
    @(negedge clk); #1;
    model(0, p, rep, 0, ab);
    model(1, p, rep, 2, ab);
    pattern_in = p;
    repeat_n   = rep[CW-1:0];
    start      = 1'b1;
    @(negedge clk); #1;
    start      = 1'b0;
    pattern_in = W'($urandom);
    repeat_n   = CW'($urandom);
    if (rst_at >= 0) begin
      repeat (rst_at) @(negedge clk);
      hold = 1'b1;
      #2 reset = 1'b1;
      #1;
      cmp("async_rst0", {ready0, d_valid0, d_out0, done0, present0}, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
      cmp("async_rst2", {ready1, d_valid1, d_out1, done1, present1}, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
      q0.delete();
      q1.delete();
      @(negedge clk); #1;
      reset = 1'b0;
      hold  = 1'b0;
    end
    if (ab >= 0) begin
      repeat (ab) @(negedge clk);
      #1 abort = 1'b1;
      @(negedge clk); #1;
      abort = 1'b0;
    end
    if (busy) begin
      @(negedge clk); #1;
      start      = 1'b1;
      pattern_in = W'($urandom);
      repeat_n   = CW'($urandom_range(1, 15));
      @(negedge clk); #1;
      start = 1'b0;
    end
    drain();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern_in = '0; repeat_n = '0;
    #2;
    cmp("reset0", {ready0, d_valid0, d_out0, done0, present0}, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    cmp("reset2", {ready1, d_valid1, d_out1, done1, present1}, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    #3 reset = 1'b0;

    run(4'b1010, 1, -1, 1'b0, -1);
    run(4'b1010, 3, -1, 1'b1, -1);
    run(4'b1100, 2, -1, 1'b0, -1);
    run(4'b0110, 0, -1, 1'b0, -1);
    run(4'b1010, 3, 1, 1'b0, -1);
    run(4'b1010, 3, -1, 1'b0, 2);
    run(4'b1011, 1, -1, 1'b0, -1);
    run(4'b1001, 15, -1, 1'b0, -1);

    // start and abort together in IDLE: no transfer
    @(negedge clk); #1;
    q0.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    q1.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    pattern_in = 4'b1111; repeat_n = 4'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; abort = 1'b0;
    drain();

    for (int n = 0; n < 30; n++) begin
      int rep, ab;
      bit busy;
      rep  = $urandom_range(0, 4);
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      busy = (ab < 0 && rep > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      run(W'($urandom), rep, ab, busy, -1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
